// File: rtl/sd_host_phy_core.sv
// sd_host_phy_core: vendor-neutral SD host PHY core.
//   Divides clk into the SD clock (runtime half-period i_clk_div+1), gates it
//   glitch-free (always stops low), launches CMD/DAT on the SD-clock fall
//   (plus the rise in DDR), and captures CMD/DAT SAMPLE_DELAY clk cycles after
//   each SD-clock edge.
// Ports:
//   clk, rst (sync, active high)
//   i_clk_div, i_clk_en         : divider / run enable
//   i_ddr_en, i_read_wait       : DDR select, SDIO read-wait request
//   i_sd_cmd_*, i_sd_data_*     : launch data/direction from the engines
//   o_sd_cmd_in, o_sd_data_in   : captured data (upper half = first beat)
//   o_rise_stb, o_fall_stb      : first clk cycle of each new SD-clock level
//   o_rx_stb, o_locked          : capture valid, PHY ready
//   o_phy_*, i_phy_*            : pad-side clock, out/oe/in
// Optional feature macro SD_PHY_CLK_AUTOSTOP_EN adds i_rx_ready, which pauses
// the SD clock during reads while the receive side is not ready.
module sd_host_phy_core #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned LOCK_CYCLES  = 16,
  parameter int unsigned SAMPLE_DELAY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                i_clk_div,
  input  logic                      i_clk_en,
  input  logic                      i_ddr_en,
  input  logic                      i_read_wait,
  input  logic                      i_sd_cmd_dir,
  input  logic                      i_sd_cmd_out,
  output logic                      o_sd_cmd_in,
  input  logic                      i_sd_data_dir,
  input  logic [2*DATA_WIDTH-1:0]   i_sd_data_out,
  output logic [2*DATA_WIDTH-1:0]   o_sd_data_in,
  output logic                      o_rise_stb,
  output logic                      o_fall_stb,
  output logic                      o_rx_stb,
  output logic                      o_locked,
  output logic                      o_phy_clk,
  output logic                      o_phy_cmd_out,
  output logic                      o_phy_cmd_oe,
  input  logic                      i_phy_cmd_in,
`ifdef SD_PHY_CLK_AUTOSTOP_EN
  input  logic                      i_rx_ready,
`endif
  output logic [DATA_WIDTH-1:0]     o_phy_data_out,
  output logic [DATA_WIDTH-1:0]     o_phy_data_oe,
  input  logic [DATA_WIDTH-1:0]     i_phy_data_in
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned LW = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam bit          RW_OK = (DATA_WIDTH >= 4);
  // Read-wait holds DAT2 low; all other lanes released.
  localparam logic [DW-1:0] RW_OE  = RW_OK ? DW'(4) : '0;
  localparam logic [DW-1:0] RW_OUT = ~RW_OE;

  typedef enum logic [1:0] {STOPPED, RUN_HI, RUN_LO} clk_state_e;

  clk_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, div_q, div_d;
  logic       rise_d, fall_d, allow, tc;

`ifdef SD_PHY_CLK_AUTOSTOP_EN
  assign allow = i_clk_en & (i_sd_data_dir | i_rx_ready);
`else
  assign allow = i_clk_en;
`endif

  assign tc = (cnt_q == div_q);

  // Clock FSM next state: a rise needs allow, a fall never waits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    div_d   = div_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STOPPED: begin
        if (!allow) begin
          cnt_d = 8'd0;
        end else if (tc) begin
          cnt_d   = 8'd0;
          div_d   = i_clk_div;
          state_d = RUN_HI;
          rise_d  = 1'b1;
        end
      end
      RUN_HI: begin
        if (tc) begin
          cnt_d   = 8'd0;
          div_d   = i_clk_div;
          state_d = RUN_LO;
          fall_d  = 1'b1;
        end
      end
      RUN_LO: begin
        if (tc) begin
          cnt_d = 8'd0;
          div_d = i_clk_div;
          if (allow) begin
            state_d = RUN_HI;
            rise_d  = 1'b1;
          end else begin
            state_d = STOPPED;
          end
        end
      end
      default: state_d = STOPPED;
    endcase
  end

  // Clock FSM state and registered clock/strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STOPPED;
      cnt_q      <= 8'd0;
      div_q      <= i_clk_div;
      o_phy_clk  <= 1'b0;
      o_rise_stb <= 1'b0;
      o_fall_stb <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      o_phy_clk  <= (state_d == RUN_HI);
      o_rise_stb <= rise_d;
      o_fall_stb <= fall_d;
    end
  end

  // Launch: everything on the fall; DDR second beat on the following rise.
  logic [DW-1:0] lower_q;
  logic          ddr_q, rw_q, rw_active;

  assign rw_active = i_read_wait & ~i_sd_data_dir & RW_OK;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_phy_cmd_out  <= 1'b1;
      o_phy_cmd_oe   <= 1'b0;
      o_phy_data_out <= '1;
      o_phy_data_oe  <= '0;
      lower_q        <= '1;
      ddr_q          <= 1'b0;
      rw_q           <= 1'b0;
    end else if (o_fall_stb) begin
      o_phy_cmd_out <= i_sd_cmd_out;
      o_phy_cmd_oe  <= i_sd_cmd_dir;
      ddr_q         <= i_ddr_en;
      rw_q          <= rw_active;
      lower_q       <= i_sd_data_out[DW-1:0];
      if (rw_active) begin
        o_phy_data_out <= RW_OUT;
        o_phy_data_oe  <= RW_OE;
      end else begin
        o_phy_data_out <= i_ddr_en ? i_sd_data_out[2*DW-1:DW] : i_sd_data_out[DW-1:0];
        o_phy_data_oe  <= {DW{i_sd_data_dir}};
      end
    end else if (o_rise_stb && ddr_q && !rw_q) begin
      o_phy_data_out <= lower_q;
    end
  end

  // Sample points: strobes delayed by SAMPLE_DELAY clk cycles.
  logic smp_rise, smp_fall;

  generate
    if (SAMPLE_DELAY == 0) begin : g_nodly
      assign smp_rise = o_rise_stb;
      assign smp_fall = o_fall_stb;
    end else begin : g_dly
      logic [SAMPLE_DELAY-1:0] rise_sh, fall_sh;
      always_ff @(posedge clk) begin
        if (rst) begin
          rise_sh <= '0;
          fall_sh <= '0;
        end else begin
          rise_sh <= SAMPLE_DELAY'({rise_sh, o_rise_stb});
          fall_sh <= SAMPLE_DELAY'({fall_sh, o_fall_stb});
        end
      end
      assign smp_rise = rise_sh[SAMPLE_DELAY-1];
      assign smp_fall = fall_sh[SAMPLE_DELAY-1];
    end
  endgenerate

  // Capture; the DDR mode is frozen at the rise sample so a pair never splits.
  logic rx_ddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_sd_cmd_in  <= 1'b1;
      o_sd_data_in <= '1;
      o_rx_stb     <= 1'b0;
      rx_ddr_q     <= 1'b0;
    end else begin
      o_rx_stb <= (smp_rise & ~ddr_q) | (smp_fall & rx_ddr_q);
      if (smp_rise) begin
        o_sd_cmd_in <= i_phy_cmd_in;
        rx_ddr_q    <= ddr_q;
        if (ddr_q) o_sd_data_in[2*DW-1:DW] <= i_phy_data_in;
        else       o_sd_data_in[DW-1:0]    <= i_phy_data_in;
      end
      if (smp_fall && rx_ddr_q) begin
        o_sd_data_in[DW-1:0] <= i_phy_data_in;
      end
    end
  end

  // Lock: saturating count of SD-clock rises; sticky once reached.
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (o_rise_stb && (32'(lock_cnt_q) < LOCK_CYCLES)) lock_cnt_d = lock_cnt_q + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_q <= '0;
      o_locked   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      o_locked   <= o_locked | (32'(lock_cnt_d) >= LOCK_CYCLES);
    end
  end

endmodule

// File: doc/sd_host_phy_core.md
Name: sd_host_phy_core

Overview:
- Parametrised, vendor-neutral SD host PHY core; successor to the fixed 4-lane Spartan-6 platform block.
- Generates the SD clock from the system clock with a runtime divider and clean clock gating.
- Supports 1/4/8 data lanes, SDR or DDR data, and programmable input-sample delay.
- Sits between the SD command/data engines and a thin pad wrapper; exposes separate out/oe/in pad signals.

Parameters:
- DATA_WIDTH, 4, number of DAT lanes (1, 4 or 8).
- LOCK_CYCLES, 16, SD-clock rising edges after reset before o_locked asserts.
- SAMPLE_DELAY, 0, clk cycles after the SD-clock edge before inputs are captured; must be less than the half period.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_clk_div  in  8  half-period of the SD clock, in clk cycles, minus 1.
- i_clk_en  in  1  SD clock run enable.
- i_ddr_en  in  1  1 = DDR data, 0 = SDR.
- i_read_wait  in  1  SDIO read-wait request.
- i_sd_cmd_dir  in  1  1 = host drives CMD.
- i_sd_cmd_out  in  1  CMD bit to launch.
- o_sd_cmd_in  out  1  captured CMD bit.
- i_sd_data_dir  in  1  1 = host drives DAT.
- i_sd_data_out  in  2*DATA_WIDTH  data to launch; upper half = first beat.
- o_sd_data_in  out  2*DATA_WIDTH  captured data; upper half = first beat.
- o_rise_stb  out  1  one-cycle pulse, first clk cycle o_phy_clk is high.
- o_fall_stb  out  1  one-cycle pulse, first clk cycle o_phy_clk is low.
- o_rx_stb  out  1  captured inputs valid (one cycle).
- o_locked  out  1  PHY ready.
- o_phy_clk  out  1  SD clock to pad.
- o_phy_cmd_out / o_phy_cmd_oe  out  1 / 1  CMD pad drive and enable.
- i_phy_cmd_in  in  1  CMD pad input.
- o_phy_data_out / o_phy_data_oe  out  DATA_WIDTH / DATA_WIDTH  DAT pad drive and per-lane enable.
- i_phy_data_in  in  DATA_WIDTH  DAT pad input.

Behaviour:
Reset values:
- o_phy_clk=0, all oe=0, o_phy_cmd_out=1, o_phy_data_out all 1, o_sd_cmd_in=1, o_sd_data_in all 1.
- o_locked=0, all strobes 0.
- Divider counter 0, lock counter 0.
- rst mid-operation returns all of the above on the next clk edge.

Clock generation:
- div_q is latched from i_clk_div at reset and at every toggle; a mid-run change takes effect on the following half period.
- Counter counts 0..div_q; at div_q it resets to 0 and toggles o_phy_clk if the toggle is allowed.
- Period = 2*(div_q+1) clk cycles; i_clk_div=0 gives clk/2.
- States: STOPPED (clock low), RUN_HI, RUN_LO.
- RUN_LO to RUN_HI only if i_clk_en=1.
- RUN_HI to RUN_LO always, so the clock never stops high and no runt pulse is produced.
- i_clk_en=0 while high: one full high phase, then the clock stays low in STOPPED.
- Re-enable: first rise div_q+1 cycles after i_clk_en is seen high.
- o_rise_stb / o_fall_stb coincide with the first cycle of each new o_phy_clk level.

Launch (registered, updated on the o_fall_stb cycle):
- cmd_out <= i_sd_cmd_out; cmd_oe <= i_sd_cmd_dir.
- SDR: data_out <= i_sd_data_out[DATA_WIDTH-1:0].
- DDR: the fall launches the upper half and the following rise launches the lower half.
- data_oe <= {DATA_WIDTH{i_sd_data_dir}}.

Read-wait:
- Applies when i_read_wait=1, i_sd_data_dir=0 and DATA_WIDTH>=4.
- DAT2 is driven 0 with oe=1; other lanes oe=0.
- Ignored when DATA_WIDTH=1.

Capture:
- CMD is sampled SAMPLE_DELAY cycles after o_rise_stb (SAMPLE_DELAY=0: on the o_rise_stb cycle).
- SDR: DAT is sampled at the same point into the lower half; o_rx_stb pulses the cycle after the sample.
- DDR: the rise sample goes to the upper half and the fall sample to the lower half; o_rx_stb pulses once per SD cycle, after the fall sample.
- i_ddr_en is latched at each o_fall_stb; a change never splits a pair.

Lock:
- Lock counter increments on o_rise_stb and saturates.
- o_locked=1 once the count reaches LOCK_CYCLES; clock gating does not clear it.

Optional Feature:
SD_PHY_CLK_AUTOSTOP_EN
- Adds input i_rx_ready (1 bit).
- With it: while i_sd_data_dir=0 and i_rx_ready=0, the rise is suppressed exactly as for i_clk_en=0, so the card is paused on FIFO full. Resumes div_q+1 cycles after i_rx_ready returns to 1.
- Without it: the port is absent and only i_clk_en gates the clock.

Test Plan:
- Reset, i_clk_div=4, i_clk_en=1 -> o_phy_clk period 10 clk cycles; o_locked rises 1 cycle after the 16th o_rise_stb; reset values checked during rst.
- i_clk_div changed 4->1 mid-high-phase -> current half period still 5 cycles, subsequent half periods 2 cycles, no glitch.
- i_clk_en dropped 1 cycle after o_rise_stb (div=3) -> high lasts 4 cycles, then low indefinitely; re-enable -> rise after 4 cycles.
- DDR, i_sd_data_dir=1, i_sd_data_out=8'hA5, width 4 -> pads 4'hA after the fall, 4'h5 after the next rise; loopback pads into input -> o_sd_data_in=8'hA5 with a single o_rx_stb.
- i_read_wait=1, i_sd_data_dir=0 -> o_phy_data_oe=4'b0100, o_phy_data_out[2]=0.
- SDR, SAMPLE_DELAY=2, CMD pad toggled 1 cycle after rise -> o_sd_cmd_in reflects the new value; toggled 3 cycles after rise -> old value.
